// File: rtl/xp_out_arbiter.sv
// xp_out_arbiter: output-port scheduler for one crosspoint router output.
//
// Shares one output port between NUM_IN requesters. When no packet is in flight,
// requesters are served round-robin. A granted packet then holds the port from its
// head flit to its tail flit (wormhole lock). Each virtual channel has a credit
// counter: an accepted flit takes one credit, and a downstream credit_return gives
// one back. Accepted flits go through a single output register.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   in_valid/in_flit/
//   in_vc_id/in_tail         per-requester flit offer
//   in_ready                 one-hot grant; the flit is taken on in_valid & in_ready
//   out_valid/out_ready/
//   out_flit/out_vc_id       registered master side of the output port
//   out_channel_type         constant CHAN_TYPE
//   credit_return(_vc)       downstream freed one buffer on the given VC
//   credit_count             current credits per VC
//   credit_err               sticky flag for a credit returned above VC_CREDITS
module xp_out_arbiter #(
  parameter int unsigned NUM_IN     = 5,
  parameter int unsigned NUM_VC     = 4,
  parameter int unsigned VC_CREDITS = 4,
  parameter int unsigned CRED_W     = $clog2(VC_CREDITS + 1),
  parameter int unsigned FLIT_W     = 64,
  parameter logic [1:0]  CHAN_TYPE  = 2'b00
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0]             in_valid,
  input  logic [NUM_IN-1:0][FLIT_W-1:0] in_flit,
  input  logic [NUM_IN-1:0][1:0]        in_vc_id,
  input  logic [NUM_IN-1:0]             in_tail,
  output logic [NUM_IN-1:0]             in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FLIT_W-1:0]             out_flit,
  output logic [1:0]                    out_vc_id,
  output logic [1:0]                    out_channel_type,
  input  logic                          credit_return,
  input  logic [1:0]                    credit_return_vc,
  output logic [NUM_VC-1:0][CRED_W-1:0] credit_count,
  output logic                          credit_err
);

  localparam int unsigned IdxW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                        state_q;
  logic [IdxW-1:0]               rr_ptr_q, lock_id_q;
  logic                          out_valid_q;
  logic [FLIT_W-1:0]             out_flit_q;
  logic [1:0]                    out_vc_q;
  logic [NUM_VC-1:0][CRED_W-1:0] credit_q, credit_d;
  logic                          credit_err_q, credit_err_d;

  logic                          slot_free;
  logic [NUM_IN-1:0]             eligible, grant;
  logic [IdxW-1:0]               grant_idx, rr_next;
  logic                          accept;
  logic [1:0]                    grant_vc;
  logic [NUM_VC-1:0]             cred_dec, cred_inc;
  int unsigned                   cand;

  // The output register can take a new flit when it is empty or draining this cycle.
  assign slot_free = !out_valid_q || out_ready;

  // Only registered credits are used here, so a credit returned this cycle
  // cannot be spent until the next cycle.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      eligible[i] = !rst && in_valid[i] && slot_free &&
                    (32'(in_vc_id[i]) < NUM_VC) && (credit_q[in_vc_id[i]] != '0) &&
                    ((state_q == StIdle) || (lock_id_q == IdxW'(i)));
    end
  end

  // Take the first eligible requester at or after rr_ptr. While locked, only
  // lock_id can be eligible, so this same search also yields the locked grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_IN;
      if ((grant == '0) && eligible[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IdxW'(cand);
      end
    end
  end

  assign accept   = |grant;
  assign grant_vc = in_vc_id[grant_idx];
  assign rr_next  = (grant_idx == IdxW'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;

  // A take and a return on the same VC cancel out. A return with no take at
  // full credit leaves the count at VC_CREDITS and sets the error flag.
  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    cred_dec     = '0;
    cred_inc     = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      cred_dec[v] = accept && (32'(grant_vc) == v);
      cred_inc[v] = credit_return && (32'(credit_return_vc) == v);
      if (cred_dec[v] && !cred_inc[v]) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end else if (cred_inc[v] && !cred_dec[v]) begin
        if (credit_q[v] == CRED_W'(VC_CREDITS)) begin
          credit_err_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      lock_id_q    <= '0;
      out_valid_q  <= 1'b0;
      out_flit_q   <= '0;
      out_vc_q     <= '0;
      credit_err_q <= 1'b0;
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        credit_q[v] <= CRED_W'(VC_CREDITS);
      end
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_flit_q  <= in_flit[grant_idx];
        out_vc_q    <= grant_vc;
        if (in_tail[grant_idx]) begin
          state_q  <= StIdle;
          rr_ptr_q <= rr_next;
        end else begin
          state_q   <= StLocked;
          lock_id_q <= grant_idx;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign in_ready         = grant;
  assign out_valid        = out_valid_q;
  assign out_flit         = out_flit_q;
  assign out_vc_id        = out_vc_q;
  assign out_channel_type = CHAN_TYPE;
  assign credit_count     = credit_q;
  assign credit_err       = credit_err_q;

endmodule

// File: tb/tb_xp_out_arbiter.sv
// Testbench for xp_out_arbiter. Each cycle a reference model decides which requester
// should be granted; accepted flits are queued, and a monitor pops and compares them
// as the output port hands them off.
module tb_xp_out_arbiter;

  localparam int NI  = 5;
  localparam int NV  = 4;
  localparam int VCC = 4;
  localparam int CW  = 3;
  localparam int FW  = 64;
  localparam logic [1:0] CT = 2'b10;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NI-1:0]         in_valid;
  logic [NI-1:0][FW-1:0] in_flit;
  logic [NI-1:0][1:0]    in_vc_id;
  logic [NI-1:0]         in_tail;
  logic [NI-1:0]         in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [FW-1:0]         out_flit;
  logic [1:0]            out_vc_id;
  logic [1:0]            out_channel_type;
  logic                  credit_return;
  logic [1:0]            credit_return_vc;
  logic [NV-1:0][CW-1:0] credit_count;
  logic                  credit_err;

  xp_out_arbiter #(
    .NUM_IN    (NI),
    .NUM_VC    (NV),
    .VC_CREDITS(VCC),
    .CRED_W    (CW),
    .FLIT_W    (FW),
    .CHAN_TYPE (CT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_flit         (in_flit),
    .in_vc_id        (in_vc_id),
    .in_tail         (in_tail),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_flit        (out_flit),
    .out_vc_id       (out_vc_id),
    .out_channel_type(out_channel_type),
    .credit_return   (credit_return),
    .credit_return_vc(credit_return_vc),
    .credit_count    (credit_count),
    .credit_err      (credit_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int   m_cred[NV];
  int   m_lock;        // -1 when no packet is in flight
  int   m_rr;
  logic m_out_valid;
  logic m_err;
  bit   m_known = 1'b0;
  logic [FW+1:0] exp_q[$];

  logic [NI-1:0] obs_ready;
  logic [FW-1:0] obs_flit;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Which requester the port should serve this cycle, from the arbitration rules.
  function automatic int model_grant();
    int i;
    if (rst) return -1;
    if (m_out_valid && !out_ready) return -1;
    if (m_lock >= 0) begin
      if (in_valid[m_lock] && m_cred[in_vc_id[m_lock]] > 0) return m_lock;
      return -1;
    end
    for (int k = 0; k < NI; k++) begin
      i = (m_rr + k) % NI;
      if (in_valid[i] && m_cred[in_vc_id[i]] > 0) return i;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NI-1:0] v);
    for (int i = 0; i < NI; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) m_cred[v] = VCC;
    m_lock      = -1;
    m_rr        = 0;
    m_out_valid = 1'b0;
    m_err       = 1'b0;
    exp_q.delete();
    m_known     = 1'b1;
  endtask

  // One clock cycle: inputs are already driven; check at negedge, advance the model.
  task automatic step();
    int            g;
    int            nxt;
    logic [NI-1:0] exp_rdy;
    @(negedge clk);
    g = model_grant();
    exp_rdy = (g >= 0) ? (NI'(1) << g) : '0;
    obs_ready = in_ready;
    obs_flit  = out_flit;
    chk("in_ready", in_ready, exp_rdy);
    if (m_known) begin
      chk("out_valid", out_valid, m_out_valid);
      for (int v = 0; v < NV; v++) begin
        chk($sformatf("credit_count[%0d]", v), credit_count[v], m_cred[v]);
      end
      chk("credit_err", credit_err, m_err);
    end
    if (rst) begin
      model_reset();
    end else begin
      if (g >= 0) exp_q.push_back({in_vc_id[g], in_flit[g]});
      for (int v = 0; v < NV; v++) begin
        nxt = m_cred[v];
        if (g >= 0 && int'(in_vc_id[g]) == v) nxt--;
        if (credit_return && int'(credit_return_vc) == v) nxt++;
        if (nxt > VCC) begin
          nxt   = VCC;
          m_err = 1'b1;
        end
        m_cred[v] = nxt;
      end
      if (g >= 0) begin
        m_out_valid = 1'b1;
        if (in_tail[g]) begin
          m_lock = -1;
          m_rr   = (g + 1) % NI;
        end else begin
          m_lock = g;
        end
      end else if (out_ready) begin
        m_out_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic v, input logic [1:0] vc, input logic tail);
    in_valid[i] = v;
    in_vc_id[i] = vc;
    in_tail[i]  = tail;
    in_flit[i]  = {$urandom, $urandom};
  endtask

  task automatic rand_cycle();
    logic [1:0] rv;
    for (int i = 0; i < NI; i++) begin
      set_in(i, $urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
    end
    out_ready        = $urandom_range(0, 3) != 0;
    rv               = 2'($urandom_range(0, 3));
    credit_return_vc = rv;
    credit_return    = ($urandom_range(0, 1) == 1) && (m_cred[rv] < VCC);
    step();
  endtask

  // Monitor: every flit the port hands off must be the next one the model queued.
  initial begin
    logic [FW+1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got flit %0h with no flit expected", out_flit);
        end else begin
          e = exp_q.pop_front();
          chk("out_flit", out_flit, e[FW-1:0]);
          chk("out_vc_id", out_vc_id, e[FW+1:FW]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int   rr_exp[6] = '{0, 2, 4, 0, 2, 4};
  int   rr_seen[6];
  int   grants;
  logic [FW-1:0] bp_flit;

  initial begin
    in_valid         = '0;
    in_flit          = '0;
    in_vc_id         = '0;
    in_tail          = '0;
    out_ready        = 1'b1;
    credit_return    = 1'b0;
    credit_return_vc = '0;

    // Reset for two cycles, then check the reset state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_in_ready", obs_ready, 0);
    chk("chan_type", out_channel_type, CT);

    // Round-robin among inputs 0, 2 and 4, with VC0 credit returned every cycle.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NI; i += 2) set_in(i, 1'b1, 2'd0, 1'b1);
      credit_return    = 1'b1;
      credit_return_vc = 2'd0;
      step();
      rr_seen[c] = onehot_idx(obs_ready);
    end
    in_valid      = '0;
    credit_return = 1'b0;
    for (int c = 0; c < 6; c++) chk($sformatf("rr_order[%0d]", c), rr_seen[c], rr_exp[c]);
    step();

    // Wormhole: input 1 sends a 3-flit packet on VC2 while input 3 waits.
    set_in(3, 1'b1, 2'd0, 1'b1);
    set_in(1, 1'b1, 2'd2, 1'b0);
    step();
    chk("wh_head", obs_ready, 5'b00010);
    set_in(1, 1'b1, 2'd2, 1'b0);
    step();
    chk("wh_body", obs_ready, 5'b00010);
    in_valid[1] = 1'b0;
    step();
    chk("wh_stall0", obs_ready, 5'b00000);
    step();
    chk("wh_stall1", obs_ready, 5'b00000);
    set_in(1, 1'b1, 2'd2, 1'b1);
    step();
    chk("wh_tail", obs_ready, 5'b00010);
    in_valid[1] = 1'b0;
    set_in(0, 1'b1, 2'd0, 1'b1);
    set_in(3, 1'b1, 2'd0, 1'b1);
    step();
    chk("wh_after_rr2", obs_ready, 5'b01000);
    in_valid = '0;
    step();

    // Credit exhaustion on VC1, then a single credit return.
    grants = 0;
    for (int c = 0; c < 5; c++) begin
      set_in(0, 1'b1, 2'd1, 1'b1);
      step();
      if (obs_ready[0]) grants++;
    end
    chk("exhaust_grants", grants, 4);
    chk("exhaust_vc1_count", credit_count[1], 0);
    credit_return    = 1'b1;
    credit_return_vc = 2'd1;
    step();
    chk("credit_not_yet", obs_ready, 5'b00000);
    credit_return = 1'b0;
    step();
    chk("credit_visible", obs_ready, 5'b00001);
    in_valid = '0;
    step();

    // Backpressure: output held while out_ready is low, then drain and refill together.
    out_ready = 1'b0;
    set_in(2, 1'b1, 2'd0, 1'b1);
    bp_flit = in_flit[2];
    step();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_ready_low", obs_ready, 5'b00000);
      chk("bp_flit_hold", obs_flit, bp_flit);
    end
    out_ready = 1'b1;
    set_in(2, 1'b1, 2'd0, 1'b1);
    step();
    chk("bp_refill", obs_ready, 5'b00100);
    in_valid = '0;
    step();

    // Credit corners on VC3: take plus return nets to zero; return at full sets the error.
    set_in(4, 1'b1, 2'd3, 1'b1);
    credit_return    = 1'b1;
    credit_return_vc = 2'd3;
    step();
    in_valid = '0;
    step();
    credit_return = 1'b0;
    step();
    chk("vc3_count", credit_count[3], VCC);
    chk("err_set", credit_err, 1'b1);
    step();
    chk("err_sticky", credit_err, 1'b1);

    // Random traffic, a reset in the middle of it, then more random traffic.
    for (int c = 0; c < 400; c++) rand_cycle();
    credit_return = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = '0;
    step();
    chk("reset_clears_err", credit_err, 1'b0);
    for (int c = 0; c < 300; c++) rand_cycle();

    in_valid      = '0;
    out_ready     = 1'b1;
    credit_return = 1'b0;
    step();
    step();
    step();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
